// File: rtl/serial_parity_tx_pkg.sv
// Shared definitions for the serial parity transmitter:
// FSM encodings, default width and parity-sense constants.
package serial_parity_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int unsigned DATA_W_DEF = 8;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_tx_shift_reg.sv
// Loadable right-shift register with bit counter.
// Load wins over advance so back-to-back frames reuse the last-bit edge.
module serial_parity_tx_shift_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CW     = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              cur_bit_o,
  output logic [CW-1:0]     cnt_o
);

  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = din_i;
      cnt_d   = '0;
    end else if (adv_i) begin
      shreg_d = shreg_q >> 1;
      // saturate so the counter never wraps past the last bit
      if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cur_bit_o = shreg_q[0];
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/serial_parity_tx.sv
// LSB-first serializer with optional trailing parity bit.
// Handshake and frame FSM live here; shifting is in the sub-module.
module serial_parity_tx
  import serial_parity_tx_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter bit          PAR_EN  = 1'b1,
  parameter bit          ODD_PAR = PAR_EVEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              en,
  output logic              x,
  output logic              bit_valid,
  output logic              frame_last,
  output logic              busy
);

  localparam int unsigned   CW   = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_e        state_q;
  logic          acc_q;
  logic          sh_bit;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          last;
  logic          accept;
  logic          adv;
  logic          pbit;
  logic          cur_bit;

  serial_parity_tx_shift_reg #(
    .DATA_W (DATA_W),
    .CW     (CW)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept),
    .adv_i     (adv),
    .din_i     (din),
    .cur_bit_o (sh_bit),
    .cnt_o     (cnt)
  );

  assign cnt_last = (cnt == LAST);
  assign busy     = (state_q != IDLE);
  assign last     = (state_q == PARITY) |
                    ((state_q == SHIFT) & cnt_last & ~PAR_EN);

  assign load_ready = (state_q == IDLE) | (last & en);
  assign accept     = load_valid & load_ready;
  assign adv        = en & (state_q == SHIFT);

  assign pbit = acc_q ^ ODD_PAR;

  always_comb begin
    cur_bit = 1'b0;
    unique case (1'b1)
      (state_q == SHIFT):  cur_bit = sh_bit;
      (state_q == PARITY): cur_bit = pbit;
      default:             cur_bit = 1'b0;
    endcase
  end

  assign bit_valid  = busy & en;
  assign x          = bit_valid & cur_bit;
  assign frame_last = bit_valid & last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
    end else if (accept) begin
      state_q <= SHIFT;
      acc_q   <= ^din;
    end else if (en) begin
      unique case (state_q)
        SHIFT:   if (cnt_last) state_q <= PAR_EN ? PARITY : IDLE;
        PARITY:  state_q <= IDLE;
        default: state_q <= state_q;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_tx.sv
// Scoreboard bench: even- and odd-parity instances share stimulus;
// expected bits are queued at accept and popped by a negedge monitor.
module tb_serial_parity_tx;
  import serial_parity_tx_pkg::*;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       load_valid;
  logic       en;

  logic lr_e, x_e, bv_e, fl_e, bz_e;
  logic lr_o, x_o, bv_o, fl_o, bz_o;

  exp_t q_e[$];
  exp_t q_o[$];

  int n_pass  = 0;
  int n_total = 0;
  int run     = 0;
  int max_run = 0;

  always #5 clk = ~clk;

  serial_parity_tx #(
    .DATA_W  (8),
    .PAR_EN  (1'b1),
    .ODD_PAR (PAR_EVEN)
  ) dut_e (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (lr_e),
    .en         (en),
    .x          (x_e),
    .bit_valid  (bv_e),
    .frame_last (fl_e),
    .busy       (bz_e)
  );

  serial_parity_tx #(
    .DATA_W  (8),
    .PAR_EN  (1'b1),
    .ODD_PAR (PAR_ODD)
  ) dut_o (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (lr_o),
    .en         (en),
    .x          (x_o),
    .bit_valid  (bv_o),
    .frame_last (fl_o),
    .busy       (bz_o)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, req, $time);
  endtask

  // hand model: LSB-first data bits then parity with chosen sense
  task automatic push_frame(input logic [7:0] w);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.b = w[i];
      e.last = 1'b0;
      q_e.push_back(e);
      q_o.push_back(e);
    end
    e.last = 1'b1;
    e.b = ^w;
    q_e.push_back(e);
    e.b = ~(^w);
    q_o.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bv_e) begin
      run++;
      if (run > max_run) max_run = run;
      if (q_e.size() == 0) chk("even_extra_bit", 1, 0);
      else begin
        e = q_e.pop_front();
        chk("even_x", x_e, e.b);
        chk("even_last", fl_e, e.last);
        chk("even_ready", lr_e, e.last);
      end
    end else begin
      run = 0;
      chk("even_idle_x", x_e, 0);
      chk("even_idle_last", fl_e, 0);
      if (bz_e) chk("even_stall_ready", lr_e, 0);
    end
    if (bv_o) begin
      if (q_o.size() == 0) chk("odd_extra_bit", 1, 0);
      else begin
        e = q_o.pop_front();
        chk("odd_x", x_o, e.b);
        chk("odd_last", fl_o, e.last);
      end
    end else begin
      chk("odd_idle_x", x_o, 0);
    end
  end

  task automatic send(input logic [7:0] w);
    bit done = 0;
    din = w;
    load_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (lr_e) begin
        push_frame(w);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        din = 8'($urandom);
        done = 1;
      end
    end
    if (!done) begin
      chk("accept_timeout", 0, 1);
      load_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!bz_e && q_e.size() == 0 && q_o.size() == 0) done = 1;
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    logic [3:0] pat;
    reset = 1'b1;
    load_valid = 1'b1;
    din = 8'hFF;
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_x", x_e, 0);
    chk("rst_bv", bv_e, 0);
    chk("rst_busy", bz_e, 0);
    chk("rst_ready", lr_e, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_accept", bz_e, 0);
    @(posedge clk);
    #1;

    send(8'hA5);
    wait_idle();
    send(8'h07);
    wait_idle();
    send(8'h00);
    wait_idle();

    // stall pattern 1,0,0,1: 9 bits need 17 busy cycles
    pat = 4'b1001;
    send(8'hA5);
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      en = pat[3 - (i % 4)];
      @(negedge clk);
      if (!bz_e) break;
      cyc++;
      @(posedge clk);
      #1;
    end
    chk("stall_duration", cyc, 17);
    en = 1'b1;
    wait_idle();

    max_run = 0;
    send(8'h01);
    send(8'hFF);
    wait_idle();
    chk("b2b_run", max_run, 18);

    send(8'hF0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    q_e.delete();
    q_o.delete();
    #1;
    chk("midrst_x", x_e, 0);
    chk("midrst_busy", bz_e, 0);
    chk("midrst_ready", lr_e, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(8'h3C);
    wait_idle();

    chk("q_even_empty", q_e.size(), 0);
    chk("q_odd_empty", q_o.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_parity_tx.md
Name: serial_parity_tx

Overview:
- Upstream bit-source for the serial parity checker.
- Accepts a parallel word over a valid/ready handshake and emits it LSB-first on a one-bit stream `x`, one bit per enabled clock.
- Optionally appends a parity bit, so that after each frame the total ones count is even (or odd). A downstream running-parity FSM then returns to its reset state at every frame boundary.
- Idle and stall cycles drive `x`=0, which leaves downstream parity state unchanged.

Parameters:
- DATA_W, 8, data bits per frame (legal range 2..32).
- PAR_EN, 1, 1 = append parity bit after data; 0 = data bits only.
- ODD_PAR, 0, 0 = total ones per frame (data plus parity) even; 1 = total ones odd. Ignored when PAR_EN=0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_W  parallel word to transmit.
- load_valid  input  1  din is valid.
- load_ready  output  1  block accepts din on this edge if load_valid=1.
- en  input  1  bit-advance enable; 0 stalls the stream.
- x  output  1  serial bit to the downstream parity stage.
- bit_valid  output  1  x carries a frame bit this cycle.
- frame_last  output  1  current bit is the final bit of the frame.
- busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous and active-high.
- Reset state: state=IDLE, shift register=0, bit counter=0, parity accumulator=0.
- Outputs while in IDLE (including during and after reset): x=0, bit_valid=0, frame_last=0, busy=0, load_ready=1.
- Loads are ignored while reset is high.
- States: IDLE, SHIFT, PARITY (the PARITY state is unused when PAR_EN=0).
- Accept: a word is taken on a rising edge where load_valid & load_ready = 1. On that edge:
  - shreg <= din, cnt <= 0, acc <= ^din, state <= SHIFT.
- Outputs are combinational from registered state plus en:
  - bit_valid = busy & en.
  - x = bit_valid & cur_bit, where cur_bit = shreg[0] in SHIFT and pbit in PARITY.
  - pbit = acc ^ ODD_PAR.
- Advance: on an edge with en=1 in SHIFT, shreg >>= 1 and cnt++.
  - If cnt == DATA_W-1: go to PARITY if PAR_EN=1, else go to IDLE.
  - In PARITY with en=1, go to IDLE.
  - With en=0, all registers hold.
- Stall: en=0 forces x=0 and bit_valid=0. Bit order and content are unchanged, so the frame is only delayed.
- frame_last = bit_valid & last, where last means PARITY, or SHIFT with cnt == DATA_W-1 and PAR_EN=0.
- load_ready = (state==IDLE) | (last & en). This allows back-to-back frames with no idle gap:
  - If a new word is accepted on the last-bit edge, the next state is SHIFT with the new word, not IDLE.
- Latency: a word accepted at edge E0 presents bit0 in the cycle after E0 (when en=1).
  - With en held high, a frame takes DATA_W + PAR_EN cycles.
- Width rules:
  - cnt is clog2(DATA_W) bits wide; its maximum value is DATA_W-1, so it never wraps.
  - acc is the XOR reduction of the accepted word, captured at load time.
- Mid-frame reset: the async clear takes effect immediately (x=0, busy=0, load_ready=1) and the partial frame is abandoned. The downstream stage shares the same reset.
- din may change freely after acceptance; only the value at the accept edge is used.

Decomposition:
- Shared include (parity_defs.vh) holds:
  - state encodings IDLE/SHIFT/PARITY (2-bit);
  - default DATA_W;
  - PAR_EVEN/PAR_ODD constants, also used by the checker bench.
- One natural sub-module, tx_shift_reg: loadable right-shift register with enable plus bit counter, exposing cur_bit and cnt.
- The FSM and handshake stay in the top module.

Test Plan:
1. Reset: assert reset with load_valid=1 -> x=0, bit_valid=0, busy=0, load_ready=1; no word accepted.
2. DATA_W=8, PAR_EN=1, ODD_PAR=0, load 8'hA5, en=1 -> x = 1,0,1,0,0,1,0,1 then 0; bit_valid high for 9 cycles; frame_last only on cycle 9; downstream parity FSM ends in S0.
3. Load 8'h07 -> parity bit 1 (total ones 4). Same word with ODD_PAR=1 -> parity bit 0.
4. Load 8'hA5 with en toggling 1,0,0,1,... -> x=0 and bit_valid=0 on stall cycles; valid bits still 1,0,1,0,0,1,0,1,0; frame duration 9 + number of stall cycles.
5. load_valid held high with 8'h01 then 8'hFF -> 18 consecutive bit_valid cycles; second frame starts the cycle after the first frame's parity bit; parity bits 1 then 0; load_ready high only on the last-bit cycles.
6. Reset asserted after 3 bits of 8'hF0 -> x=0 and busy=0 immediately; the next load of 8'h3C restarts at bit0 with the full 9-bit sequence.
